vga_pixel_pipe: RTL and testbench

Framebuffer read stage that sits directly downstream of the VGA timing generator: consumes its `hcount`/`vcount`/`video_enable`/`hsync`/`vsync`, fetches pixels from an on-chip 160x120 RGB332 framebuffer with 4x pixel replication, and drives the VGA pins. Its write port is fed by the Arduino-side SPI slave. Writes are accepted only during blanking, so a single-port RAM suffices. Sync outputs are delayed to stay aligned with the RGB data.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/fb_ram.sv | 26 ++
 rtl/vga_pixel_pipe.sv | 107 ++++++++++
 tb/tb_vga_pixel_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the 640x480 VGA pixel path.
// Covers timing, framebuffer geometry and the RGB332 pixel layout.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int SCALE_LOG2 = 2;
    localparam int FB_ADDR_W  = 15;
    localparam int PIPE_LAT   = 2;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Replicate the top bits so full-scale 332 values map to full-scale 444.
    function automatic rgb444_t expand_332(input logic [7:0] pix);
        rgb444_t c;
        c.r = {pix[R_MSB:R_LSB], pix[R_MSB]};
        c.g = {pix[G_MSB:G_LSB], pix[G_MSB]};
        c.b = {pix[B_MSB:B_LSB], pix[B_MSB:B_LSB]};
        return c;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port framebuffer memory: synchronous write, registered read.
module fb_ram #(
    parameter int DEPTH  = 19200,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_pixel_pipe.sv
// Framebuffer read stage: maps screen position to a replicated framebuffer pixel,
// arbitrates the single RAM port with the write interface and aligns sync to colour.
module vga_pixel_pipe #(
    parameter int FB_W       = vga_pkg::FB_W,
    parameter int FB_H       = vga_pkg::FB_H,
    parameter int SCALE_LOG2 = vga_pkg::SCALE_LOG2,
    parameter int ADDR_W     = vga_pkg::FB_ADDR_W
) (
    input  logic              clk_25MHz,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              video_enable,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b
);
    import vga_pkg::*;

    localparam int          FB_DEPTH  = FB_W * FB_H;
    localparam logic [31:0] FB_W_BITS = 32'(FB_W);

    logic [9:0]        fb_x;
    logic [9:0]        fb_y;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              wr_in_range;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    logic [PIPE_LAT-1:0] hsync_q, hsync_d;
    logic [PIPE_LAT-1:0] vsync_q, vsync_d;
    logic                en_q, en_d;
    rgb444_t             rgb_q, rgb_d;

    assign fb_x = hcount >> SCALE_LOG2;
    assign fb_y = vcount >> SCALE_LOG2;

    // y*FB_W as a sum of shifted copies of y, one per set bit of FB_W.
    always_comb begin
        rd_addr = ADDR_W'(fb_x);
        for (int i = 0; i < 32; i++) begin
            if (FB_W_BITS[i]) begin
                rd_addr = rd_addr + (ADDR_W'(fb_y) << i);
            end
        end
    end

    // The port reads while visible and belongs to the writer during blanking.
    assign wr_ready    = ~video_enable & ~reset;
    assign wr_in_range = (wr_addr < ADDR_W'(FB_DEPTH));
    assign ram_we      = wr_valid & wr_ready & wr_in_range;
    assign ram_addr    = video_enable ? rd_addr : wr_addr;

    fb_ram #(
        .DEPTH  (FB_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_fb_ram (
        .clk_i   (clk_25MHz),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wr_data),
        .rdata_o (ram_rdata)
    );

    assign hsync_d[0] = hsync_in;
    assign vsync_d[0] = vsync_in;

    for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_sync_delay
        assign hsync_d[gi] = hsync_q[gi-1];
        assign vsync_d[gi] = vsync_q[gi-1];
    end

    // The enable only needs one stage: the colour register provides the second.
    assign en_d  = video_enable;
    assign rgb_d = en_q ? expand_332(ram_rdata) : '0;

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            hsync_q <= '1;
            vsync_q <= '1;
            en_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            en_q    <= en_d;
            rgb_q   <= rgb_d;
        end
    end

    assign vga_hsync = hsync_q[PIPE_LAT-1];
    assign vga_vsync = vsync_q[PIPE_LAT-1];
    assign vga_r     = rgb_q.r;
    assign vga_g     = rgb_q.g;
    assign vga_b     = rgb_q.b;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Randomised bench for vga_pixel_pipe against a framebuffer-level reference model.
module tb_vga_pixel_pipe;

    logic        clk_25MHz = 1'b0;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        video_enable;
    logic        hsync_in;
    logic        vsync_in;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    always #20 clk_25MHz = ~clk_25MHz;

    vga_pixel_pipe dut (
        .clk_25MHz    (clk_25MHz),
        .reset        (reset),
        .hcount       (hcount),
        .vcount       (vcount),
        .video_enable (video_enable),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .vga_hsync    (vga_hsync),
        .vga_vsync    (vga_vsync),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b)
    );

    typedef struct {
        logic [13:0] px;
        int          h;
        int          v;
        logic        en;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_fb [19200];
    int         total = 0;
    int         bad = 0;
    logic       last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)",
                     tag, obs, expv, hcount, vcount, $time);
        end
    endtask

    // RGB332 to 444 by arithmetic: scale 3-bit fields by 2 plus their MSB, 2-bit by 5.
    function automatic logic [11:0] ref_colour(input logic [7:0] p);
        int r3, g3, b2;
        r3 = int'(p) / 32;
        g3 = (int'(p) / 4) % 8;
        b2 = int'(p) % 4;
        return 12'((r3 * 2 + r3 / 4) * 256 + (g3 * 2 + g3 / 4) * 16 + b2 * 5);
    endfunction

    function automatic exp_t reset_entry();
        exp_t e;
        e.px = 14'h3000;
        e.h  = -1;
        e.v  = -1;
        e.en = 1'b0;
        return e;
    endfunction

    task automatic drive(input int h, input int v);
        hcount       = 10'(h);
        vcount       = 10'(v);
        video_enable = (h < 640) && (v < 480);
        hsync_in     = !((h >= 656) && (h <= 751));
        vsync_in     = !((v >= 490) && (v <= 491));
    endtask

    // One pixel clock: drive, predict, advance, then compare the output due now.
    task automatic step(input int h, input int v, input logic wvi, input int wai, input logic [7:0] wdi);
        exp_t e, old;
        logic en;
        drive(h, v);
        en       = (h < 640) && (v < 480);
        wr_valid = wvi;
        wr_addr  = 15'(wai);
        wr_data  = wdi;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(!en));
        last_acc = wr_valid && wr_ready;
        e.h  = h;
        e.v  = v;
        e.en = en;
        e.px = {!((h >= 656) && (h <= 751)), !((v >= 490) && (v <= 491)), 12'h000};
        if (en) e.px[11:0] = ref_colour(ref_fb[(v / 4) * 160 + h / 4]);
        if (wvi && !en && wai < 19200) ref_fb[wai] = wdi;
        exp_q.push_back(e);
        @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        if (exp_q.size() >= 2) begin
            old = exp_q.pop_front();
            chk("pix", 32'({vga_hsync, vga_vsync, vga_r, vga_g, vga_b}), 32'(old.px));
            if (old.en && old.h == 0 && old.v == 0)
                chk("origin", 32'({vga_r, vga_g, vga_b}), 32'h0F00);
            if (old.en && old.h == 639 && old.v == 479)
                chk("last", 32'({vga_r, vga_g, vga_b}), 32'h00FF);
        end
    endtask

    task automatic random_wr(output logic wvi, output int wai, output logic [7:0] wdi);
        wvi = ($urandom_range(0, 3) == 0);
        wai = $urandom_range(1, 19300);
        if (wai == 19199) wai = 19198;
        wdi = 8'($urandom);
    endtask

    task automatic run_line(input int v, input bit stall);
        int         acc_h;
        int         sa;
        logic [7:0] sd;
        logic       wvi;
        int         wai;
        logic [7:0] wdi;
        acc_h = -1;
        sa = $urandom_range(1, 19198);
        sd = 8'($urandom);
        for (int h = 0; h < 800; h++) begin
            if (stall) begin
                wvi = (h >= 100) && (acc_h < 0);
                wai = sa;
                wdi = sd;
            end else begin
                random_wr(wvi, wai, wdi);
            end
            step(h, v, wvi, wai, wdi);
            if (last_acc && acc_h < 0) acc_h = h;
        end
        if (stall) chk("stall_h", 32'(acc_h), 32'd640);
    endtask

    task automatic mid_reset(input int v, input int hstop);
        logic       wvi;
        int         wai;
        logic [7:0] wdi;
        for (int h = 0; h < hstop; h++) step(h, v, 1'b0, 0, 8'h00);
        drive(hstop, v);
        wr_valid = 1'b1;
        wr_addr  = 15'd5;
        wr_data  = 8'hA5;
        #5;
        reset = 1'b1;
        #1;
        chk("rst_hsync", 32'(vga_hsync), 32'd1);
        chk("rst_vsync", 32'(vga_vsync), 32'd1);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(reset_entry());
        for (int h = hstop + 1; h < 800; h++) begin
            random_wr(wvi, wai, wdi);
            step(h, v, wvi, wai, wdi);
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        last_acc = 1'b0;
        drive(700, 500);
        repeat (2) @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        chk("init_hsync", 32'(vga_hsync), 32'd1);
        chk("init_vsync", 32'(vga_vsync), 32'd1);
        chk("init_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("init_wr_ready", 32'(wr_ready), 32'd0);
        reset = 1'b0;
        exp_q.push_back(reset_entry());

        for (int i = 0; i < 19200; i++) step(780, 500, 1'b1, i, 8'($urandom));
        step(780, 500, 1'b1, 0, 8'hE0);
        step(780, 500, 1'b1, 19199, 8'h1F);

        for (int v = 0; v < 5; v++) run_line(v, 1'b0);
        run_line(10, 1'b1);
        for (int v = 476; v < 482; v++) run_line(v, 1'b0);
        for (int v = 489; v < 493; v++) run_line(v, 1'b0);
        run_line(524, 1'b0);

        mid_reset(490, 700);
        mid_reset(20, 300);

        step(700, 495, 1'b1, 19200, 8'hFF);
        chk("oor_acc", 32'(last_acc), 32'd1);

        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                step(4 * x + $urandom_range(0, 3), 4 * y + $urandom_range(0, 3), 1'b0, 0, 8'h00);
            end
        end
        repeat (3) step(780, 500, 1'b0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
